// File: rtl/control_cmd_watchdog_multi.sv
// -----------------------------------------------------------------------------
// control_cmd_watchdog_multi
//
// Command-stream watchdog for the control byte path. Incoming bytes are framed
// into SIG_BYTES-wide words and each completed word is compared against
// NUM_SIGS keep-alive signatures. While armed, a matching frame reloads the
// timeout counter. If the counter runs out, a sys_reset pulse of
// RESET_PULSE_TICKS cycles is issued, followed by HOLDOFF_TICKS cycles during
// which the watchdog is inhibited and command bytes are ignored.
//
// Ports
//   clk            in   1     system clock
//   reset          in   1     synchronous, active-high
//   data_in        in   8     command byte, valid when enable=1
//   enable         in   1     byte strobe, one byte per cycle
//   arm            in   1     1 = watchdog counting, 0 = disarmed
//   sys_reset      out  1     timeout reset pulse (registered)
//   done           out  1     1-cycle pulse: a frame of SIG_BYTES bytes completed
//   match_valid    out  1     1-cycle pulse with done when the frame is a signature
//   match_id       out  IDW   lowest matching signature index (held on a miss)
//   warn           out  1     running and remaining <= WARN_TICKS
//   remaining      out  CW    ticks left before the watchdog fires
//   expired_count  out  8     number of timeouts, saturating at 255
// -----------------------------------------------------------------------------
module control_cmd_watchdog_multi #(
    parameter int SIG_BYTES         = 2,
    parameter int NUM_SIGS          = 2,
    parameter logic [NUM_SIGS*SIG_BYTES*8-1:0] SIG_PATTERNS = {16'hCAFE, 16'hBEEF},
    parameter int TIMEOUT_TICKS     = 1000000,
    parameter int WARN_TICKS        = 100000,
    parameter int RESET_PULSE_TICKS = 16,
    parameter int HOLDOFF_TICKS     = 256
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [7:0]                                        data_in,
    input  logic                                              enable,
    input  logic                                              arm,
    output logic                                              sys_reset,
    output logic                                              done,
    output logic                                              match_valid,
    output logic [((NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1)-1:0] match_id,
    output logic                                              warn,
    output logic [$clog2(TIMEOUT_TICKS+1)-1:0]                remaining,
    output logic [7:0]                                        expired_count
);

    localparam int SW  = SIG_BYTES * 8;
    localparam int IDW = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1;
    localparam int CW  = $clog2(TIMEOUT_TICKS + 1);
    localparam int BCW = $clog2(SIG_BYTES + 1);
    localparam int PW  = $clog2(RESET_PULSE_TICKS + 1);
    localparam int HW  = $clog2(HOLDOFF_TICKS + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SIG_BYTES < 1) begin : g_bad_sig_bytes
        $error("control_cmd_watchdog_multi: SIG_BYTES must be >= 1");
    end
    if (NUM_SIGS < 1) begin : g_bad_num_sigs
        $error("control_cmd_watchdog_multi: NUM_SIGS must be >= 1");
    end
    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("control_cmd_watchdog_multi: TIMEOUT_TICKS must be >= 1");
    end
    if (WARN_TICKS >= TIMEOUT_TICKS) begin : g_bad_warn
        $error("control_cmd_watchdog_multi: WARN_TICKS must be < TIMEOUT_TICKS");
    end
    if (RESET_PULSE_TICKS < 1) begin : g_bad_pulse
        $error("control_cmd_watchdog_multi: RESET_PULSE_TICKS must be >= 1");
    end
    if (HOLDOFF_TICKS < 1) begin : g_bad_holdoff
        $error("control_cmd_watchdog_multi: HOLDOFF_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_RUNNING,
        ST_FIRING,
        ST_HOLDOFF
    } state_t;

    state_t           state_q,         state_d;
    logic [CW-1:0]    remaining_q,     remaining_d;
    logic [PW-1:0]    pulse_cnt_q,     pulse_cnt_d;
    logic [HW-1:0]    hold_cnt_q,      hold_cnt_d;
    logic [BCW-1:0]   byte_cnt_q,      byte_cnt_d;
    logic [SW-1:0]    cache_q,         cache_d;
    logic [7:0]       expired_count_q, expired_count_d;
    logic             sys_reset_q,     sys_reset_d;
    logic             done_q,          done_d;
    logic             match_valid_q,   match_valid_d;
    logic [IDW-1:0]   match_id_q,      match_id_d;
    logic             warn_q,          warn_d;

    logic [SW-1:0]    frame_word;
    logic             accept;
    logic             frame_last;
    logic             hit;
    logic [IDW-1:0]   hit_id;
    logic             kick;

    // The word under test includes the byte arriving this cycle, so a match
    // is recognised on the same edge that completes the frame. For a
    // single-byte frame the shifted cache contributes nothing.
    assign frame_word = (cache_q << 8) | SW'(data_in);

    // Bytes are only framed while the watchdog is idle or counting; during
    // the pulse and the hold-off they are dropped.
    assign accept     = enable && ((state_q == ST_DISARMED) || (state_q == ST_RUNNING));
    assign frame_last = accept && (byte_cnt_q == BCW'(SIG_BYTES - 1));
    assign kick       = frame_last && hit;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so
        // no path can leave it unassigned and infer a latch.
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_SIGS - 1; i >= 0; i--) begin
            if (frame_word == SIG_PATTERNS[i*SW +: SW]) begin
                hit    = 1'b1;
                hit_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        pulse_cnt_d     = pulse_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        cache_d         = cache_q;
        expired_count_d = expired_count_q;
        sys_reset_d     = 1'b0;
        done_d          = 1'b0;
        match_valid_d   = 1'b0;
        match_id_d      = match_id_q;

        // Framing: the last byte of a frame clears counter and cache on the
        // same edge, so the next byte immediately starts a new frame.
        if (accept) begin
            if (frame_last) begin
                byte_cnt_d = '0;
                cache_d    = '0;
                done_d     = 1'b1;
                if (hit) begin
                    match_valid_d = 1'b1;
                    match_id_d    = hit_id;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
                cache_d    = frame_word;
            end
        end

        unique case (state_q)
            ST_DISARMED: begin
                remaining_d = CW'(TIMEOUT_TICKS);
                if (arm) begin
                    state_d = ST_RUNNING;
                end
            end

            ST_RUNNING: begin
                if (!arm) begin
                    state_d     = ST_DISARMED;
                    remaining_d = CW'(TIMEOUT_TICKS);
                end else if (kick) begin
                    // A kick on the final tick still wins over firing.
                    remaining_d = CW'(TIMEOUT_TICKS);
                end else if (remaining_q == '0) begin
                    state_d     = ST_FIRING;
                    pulse_cnt_d = '0;
                    sys_reset_d = 1'b1;
                    byte_cnt_d  = '0;
                    cache_d     = '0;
                    if (expired_count_q != 8'hFF) begin
                        expired_count_d = expired_count_q + 8'd1;
                    end
                end else begin
                    remaining_d = remaining_q - CW'(1);
                end
            end

            ST_FIRING: begin
                // pulse_cnt_q counts completed pulse cycles; the pulse drops
                // after RESET_PULSE_TICKS cycles in this state.
                if (pulse_cnt_q == PW'(RESET_PULSE_TICKS - 1)) begin
                    state_d     = ST_HOLDOFF;
                    hold_cnt_d  = '0;
                    remaining_d = CW'(TIMEOUT_TICKS);
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                    sys_reset_d = 1'b1;
                end
            end

            ST_HOLDOFF: begin
                remaining_d = CW'(TIMEOUT_TICKS);
                if (hold_cnt_q == HW'(HOLDOFF_TICKS - 1)) begin
                    state_d = arm ? ST_RUNNING : ST_DISARMED;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end

            default: begin
                state_d = ST_DISARMED;
            end
        endcase

        // Registered from next-state values so warn lines up with remaining.
        warn_d = (state_d == ST_RUNNING) && (remaining_d <= CW'(WARN_TICKS));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q         <= ST_DISARMED;
            remaining_q     <= CW'(TIMEOUT_TICKS);
            pulse_cnt_q     <= '0;
            hold_cnt_q      <= '0;
            byte_cnt_q      <= '0;
            cache_q         <= '0;
            expired_count_q <= '0;
            sys_reset_q     <= 1'b0;
            done_q          <= 1'b0;
            match_valid_q   <= 1'b0;
            match_id_q      <= '0;
            warn_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            pulse_cnt_q     <= pulse_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            cache_q         <= cache_d;
            expired_count_q <= expired_count_d;
            sys_reset_q     <= sys_reset_d;
            done_q          <= done_d;
            match_valid_q   <= match_valid_d;
            match_id_q      <= match_id_d;
            warn_q          <= warn_d;
        end
    end

    assign sys_reset     = sys_reset_q;
    assign done          = done_q;
    assign match_valid   = match_valid_q;
    assign match_id      = match_id_q;
    assign warn          = warn_q;
    assign remaining     = remaining_q;
    assign expired_count = expired_count_q;

endmodule

// File: tb/tb_control_cmd_watchdog_multi.sv
// -----------------------------------------------------------------------------
// tb_control_cmd_watchdog_multi
//
// Directed bench for control_cmd_watchdog_multi with SIG_BYTES=2, TIMEOUT=20,
// WARN=5, PULSE=3, HOLDOFF=4. Frame results are predicted when the last byte
// of a frame is driven and compared when the DUT reports the frame; timer,
// pulse and counter behaviour is checked at hand-derived cycle points.
// -----------------------------------------------------------------------------
module tb_control_cmd_watchdog_multi;

    localparam int TO   = 20;
    localparam int WARN = 5;
    localparam int PUL  = 3;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       enable = 1'b0;
    logic       arm = 1'b0;
    logic       sys_reset;
    logic       done;
    logic       match_valid;
    logic [0:0] match_id;
    logic       warn;
    logic [4:0] remaining;
    logic [7:0] expired_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic [0:0] id;
    } exp_t;

    exp_t       sb[$];
    logic [0:0] last_id = 1'b0;

    control_cmd_watchdog_multi #(
        .SIG_BYTES        (2),
        .NUM_SIGS         (2),
        .SIG_PATTERNS     ({16'hCAFE, 16'hBEEF}),
        .TIMEOUT_TICKS    (TO),
        .WARN_TICKS       (WARN),
        .RESET_PULSE_TICKS(PUL),
        .HOLDOFF_TICKS    (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .enable       (enable),
        .arm          (arm),
        .sys_reset    (sys_reset),
        .done         (done),
        .match_valid  (match_valid),
        .match_id     (match_id),
        .warn         (warn),
        .remaining    (remaining),
        .expired_count(expired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode of a completed frame (entry 0 = BEEF, entry 1 = CAFE).
    task automatic predict(input logic [15:0] w, output exp_t e);
        if (w == 16'hBEEF) begin
            e.valid = 1'b1; e.id = 1'b0;
        end else if (w == 16'hCAFE) begin
            e.valid = 1'b1; e.id = 1'b1;
        end else begin
            e.valid = 1'b0; e.id = last_id;
        end
        last_id = e.id;
    endtask

    // One clock; outputs sampled 1 time unit after the edge. Any frame report
    // must correspond to a queued prediction, and vice versa.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done", 32'(done), 32'd1);
            check("match_valid", 32'(match_valid), 32'(e.valid));
            check("match_id", 32'(match_id), 32'(e.id));
        end else begin
            check("no_done", 32'(done), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input bit expect_out);
        exp_t e;
        enable  = 1'b1;
        data_in = b0;
        step();
        data_in = b1;
        if (expect_out) begin
            predict({b0, b1}, e);
            sb.push_back(e);
        end
        step();
        enable = 1'b0;
    endtask

    initial begin
        int highs;
        int n;

        // ---------------- reset values ----------------
        reset = 1'b1;
        idle(2);
        check("rst_sys_reset", 32'(sys_reset), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match_valid", 32'(match_valid), 32'd0);
        check("rst_match_id", 32'(match_id), 32'd0);
        check("rst_warn", 32'(warn), 32'd0);
        check("rst_remaining", 32'(remaining), 32'(TO));
        check("rst_expired", 32'(expired_count), 32'd0);

        // ---------------- 1: periodic kicks ----------------
        reset = 1'b0;
        arm   = 1'b1;
        step();
        check("armed_remaining", 32'(remaining), 32'(TO));
        for (int i = 0; i < 3; i++) begin
            frame(8'hBE, 8'hEF, 1'b1);
            check("kick_reload", 32'(remaining), 32'(TO));
            idle(8);
        end
        check("rem_after_idle", 32'(remaining), 32'd12);
        check("no_fire_periodic", 32'(sys_reset), 32'd0);
        check("no_expiry_periodic", 32'(expired_count), 32'd0);

        // ---------------- 2: second signature and a miss ----------------
        frame(8'hCA, 8'hFE, 1'b1);
        check("kick2_reload", 32'(remaining), 32'(TO));
        frame(8'h12, 8'h34, 1'b1);
        check("miss_no_reload", 32'(remaining), 32'd18);
        step();
        check("miss_keeps_counting", 32'(remaining), 32'd17);

        // ---------------- 3: timeout, pulse, hold-off ----------------
        frame(8'hCA, 8'hFE, 1'b1);
        highs = 0;
        for (int k = 1; k <= 28; k++) begin
            // Bytes offered during the pulse and hold-off must be dropped.
            if (k >= 22) begin
                enable  = 1'b1;
                data_in = (k % 2 == 0) ? 8'hBE : 8'hEF;
            end else begin
                enable = 1'b0;
            end
            step();
            if (sys_reset === 1'b1) highs++;
            if (k == 14) begin
                check("warn_low_at_6", 32'(warn), 32'd0);
                check("rem_at_6", 32'(remaining), 32'd6);
            end
            if (k == 15) begin
                check("warn_high_at_5", 32'(warn), 32'd1);
                check("rem_at_5", 32'(remaining), 32'd5);
            end
            if (k == 20) begin
                check("rem_zero", 32'(remaining), 32'd0);
                check("no_fire_at_zero", 32'(sys_reset), 32'd0);
            end
            if (k == 21) begin
                check("fire_start", 32'(sys_reset), 32'd1);
                check("expired_one", 32'(expired_count), 32'd1);
                check("warn_off_firing", 32'(warn), 32'd0);
            end
            if (k == 24) begin
                check("pulse_end", 32'(sys_reset), 32'd0);
                check("holdoff_rem", 32'(remaining), 32'(TO));
            end
            if (k == 28) check("holdoff_exit_rem", 32'(remaining), 32'(TO));
        end
        enable = 1'b0;
        check("pulse_width", 32'(highs), 32'(PUL));
        step();
        check("running_after_holdoff", 32'(remaining), 32'd19);
        check("warn_after_holdoff", 32'(warn), 32'd0);

        // ---------------- 4: kick on the final tick ----------------
        idle(18);
        check("rem_one", 32'(remaining), 32'd1);
        frame(8'hBE, 8'hEF, 1'b1);
        check("late_kick_reload", 32'(remaining), 32'(TO));
        check("late_kick_no_fire", 32'(sys_reset), 32'd0);
        step();
        check("late_kick_after", 32'(sys_reset), 32'd0);
        check("late_kick_count", 32'(remaining), 32'd19);
        check("late_kick_expired", 32'(expired_count), 32'd1);

        // ---------------- 5: disarm, then reset mid-pulse ----------------
        idle(16);
        check("pre_disarm_rem", 32'(remaining), 32'd3);
        check("pre_disarm_warn", 32'(warn), 32'd1);
        arm = 1'b0;
        step();
        check("disarm_rem", 32'(remaining), 32'(TO));
        check("disarm_warn", 32'(warn), 32'd0);
        frame(8'hCA, 8'hFE, 1'b1);
        check("disarmed_rem_held", 32'(remaining), 32'(TO));
        arm = 1'b1;
        step();
        idle(TO + 1);
        check("fire_again", 32'(sys_reset), 32'd1);
        check("expired_two", 32'(expired_count), 32'd2);
        reset   = 1'b1;
        last_id = 1'b0;
        step();
        check("midpulse_sys_reset", 32'(sys_reset), 32'd0);
        check("midpulse_expired", 32'(expired_count), 32'd0);
        check("midpulse_remaining", 32'(remaining), 32'(TO));
        check("midpulse_match_id", 32'(match_id), 32'd0);
        check("midpulse_warn", 32'(warn), 32'd0);
        check("midpulse_match_valid", 32'(match_valid), 32'd0);
        reset = 1'b0;

        // ---------------- 6: expiry counter saturation ----------------
        for (int i = 1; i <= 256; i++) begin
            n = 0;
            while (sys_reset !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            check("fire_wait", 32'(n < 40), 32'd1);
            if (i == 1)   check("expired_first", 32'(expired_count), 32'd1);
            if (i == 255) check("expired_255", 32'(expired_count), 32'd255);
            if (i == 256) check("expired_saturated", 32'(expired_count), 32'd255);
            n = 0;
            while (sys_reset === 1'b1 && n < 10) begin
                step();
                n++;
            end
            check("pulse_drop_wait", 32'(n < 10), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
